// File: rtl/irig_frame_sync.sv
// irig_frame_sync: IRIG-B frame alignment, bit-index tracking, marker checking and
// BCD time-field assembly downstream of the pulse-width symbol parser.
//
// state  | meaning
// HUNT   | no alignment; waiting for any marker
// ARMED  | one marker seen; a second marker (Pr) establishes index 0
// LOCKED | aligned; every symbol checked against the expected marker/data slot
module irig_frame_sync #(
    parameter int TIMEOUT = 2_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sym_in,
    input  logic       sym_valid,
    output logic       locked,
    output logic [6:0] bit_index,
    output logic       pps,
    output logic       time_valid,
    output logic [6:0] sec_bcd,
    output logic [6:0] min_bcd,
    output logic [5:0] hour_bcd,
    output logic [9:0] day_bcd,
    output logic [7:0] year_bcd,
    output logic       sync_err
);

    localparam int            TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] tmo_cnt;

    // Packed accumulator: {year[7:0], day[9:0], hour[5:0], min[6:0], sec[6:0]}
    logic [37:0]   acc;

    logic [6:0]    idx_inc;
    logic [6:0]    idx_nxt;
    logic          mark_slot;
    logic          is_mark;
    logic          is_data;
    logic          is_illegal;
    logic          tmo_hit;
    logic          pps_nxt;
    logic          tv_nxt;
    logic          err_nxt;
    logic          acc_clr;
    logic          acc_wr;
    logic          publish;
    logic          fld_hit;
    logic [5:0]    fld_pos;

    assign is_mark    = (sym_in == 2'd2);
    assign is_data    = ~sym_in[1];
    assign is_illegal = (sym_in == 2'd3);
    assign idx_inc    = (bit_index == 7'd99) ? 7'd0 : bit_index + 7'd1;
    assign mark_slot  = (idx_inc == 7'd0) || ((idx_inc % 7'd10) == 7'd9);
    assign tmo_hit    = (state != HUNT) && !sym_valid && (tmo_cnt == '0);
    assign locked     = (state == LOCKED);

    // Map the frame index of the incoming data bit onto its accumulator bit
    always_comb begin
        fld_hit = 1'b1;
        fld_pos = '0;
        case (idx_inc) inside
            [7'd1:7'd4]:   fld_pos = 6'(idx_inc - 7'd1);
            [7'd6:7'd8]:   fld_pos = 6'(idx_inc - 7'd2);
            [7'd10:7'd13]: fld_pos = 6'(idx_inc - 7'd3);
            [7'd15:7'd17]: fld_pos = 6'(idx_inc - 7'd4);
            [7'd20:7'd23]: fld_pos = 6'(idx_inc - 7'd6);
            [7'd25:7'd26]: fld_pos = 6'(idx_inc - 7'd7);
            [7'd30:7'd33]: fld_pos = 6'(idx_inc - 7'd10);
            [7'd35:7'd38]: fld_pos = 6'(idx_inc - 7'd11);
            [7'd40:7'd41]: fld_pos = 6'(idx_inc - 7'd12);
            [7'd50:7'd53]: fld_pos = 6'(idx_inc - 7'd20);
            [7'd55:7'd58]: fld_pos = 6'(idx_inc - 7'd21);
            default:       fld_hit = 1'b0;
        endcase
    end

    // Next-state, index and strobe decisions for the current symbol or timeout.
    // Lock is only ever entered at index 0, so any index-99 marker accepted in
    // LOCKED closes a frame whose indices 1..98 were all seen while locked.
    always_comb begin
        state_nxt = state;
        idx_nxt   = bit_index;
        pps_nxt   = 1'b0;
        tv_nxt    = 1'b0;
        err_nxt   = 1'b0;
        acc_clr   = 1'b0;
        acc_wr    = 1'b0;
        publish   = 1'b0;
        if (tmo_hit) begin
            state_nxt = HUNT;
            idx_nxt   = 7'd0;
            err_nxt   = 1'b1;
            acc_clr   = 1'b1;
        end else if (sym_valid) begin
            case (state)
                HUNT: begin
                    if (is_mark) state_nxt = ARMED;
                end
                ARMED: begin
                    if (is_mark) begin
                        state_nxt = LOCKED;
                        idx_nxt   = 7'd0;
                        pps_nxt   = 1'b1;
                        acc_clr   = 1'b1;
                    end else begin
                        state_nxt = HUNT;
                        err_nxt   = is_illegal;
                    end
                end
                LOCKED: begin
                    if (mark_slot ? is_mark : is_data) begin
                        idx_nxt = idx_inc;
                        if (idx_inc == 7'd0) begin
                            pps_nxt = 1'b1;
                            acc_clr = 1'b1;
                        end else if (idx_inc == 7'd99) begin
                            publish = 1'b1;
                            tv_nxt  = 1'b1;
                        end else begin
                            acc_wr = fld_hit;
                        end
                    end else begin
                        state_nxt = is_mark ? ARMED : HUNT;
                        idx_nxt   = 7'd0;
                        err_nxt   = 1'b1;
                        acc_clr   = 1'b1;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= HUNT;
        else     state <= state_nxt;
    end

    // Bit index and registered one-cycle strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_index  <= 7'd0;
            pps        <= 1'b0;
            time_valid <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            bit_index  <= idx_nxt;
            pps        <= pps_nxt;
            time_valid <= tv_nxt;
            sync_err   <= err_nxt;
        end
    end

    // Inter-symbol timeout down-counter, reloaded by every symbol and idle in HUNT
    always_ff @(posedge clk) begin
        if (rst)                             tmo_cnt <= '0;
        else if (sym_valid || state == HUNT) tmo_cnt <= TMO_LOAD;
        else if (tmo_cnt != '0)              tmo_cnt <= tmo_cnt - 1'b1;
    end

    // Field accumulator, written LSB-first at each data bit's slot
    always_ff @(posedge clk) begin
        if (rst || acc_clr) acc <= '0;
        else if (acc_wr)    acc[fld_pos] <= sym_in[0];
    end

    // Published time fields, updated only when a complete frame closes
    always_ff @(posedge clk) begin
        if (rst) begin
            sec_bcd  <= '0;
            min_bcd  <= '0;
            hour_bcd <= '0;
            day_bcd  <= '0;
            year_bcd <= '0;
        end else if (publish) begin
            sec_bcd  <= acc[6:0];
            min_bcd  <= acc[13:7];
            hour_bcd <= acc[19:14];
            day_bcd  <= acc[29:20];
            year_bcd <= acc[37:30];
        end
    end

endmodule

// File: tb/tb_irig_frame_sync.sv
// tb_irig_frame_sync: scenario tasks drive IRIG-B symbol streams; per-symbol expected
// strobes/lock/index go into a scoreboard queue and are compared when the DUT responds.
module tb_irig_frame_sync;

    localparam int TMO = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sym_in = 2'd0;
    logic       sym_valid = 1'b0;
    logic       locked;
    logic [6:0] bit_index;
    logic       pps;
    logic       time_valid;
    logic [6:0] sec_bcd;
    logic [6:0] min_bcd;
    logic [5:0] hour_bcd;
    logic [9:0] day_bcd;
    logic [7:0] year_bcd;
    logic       sync_err;

    typedef struct packed {
        logic       pps;
        logic       tv;
        logic       err;
        logic       lk;
        logic [6:0] idx;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] frame[100];
    int         checks = 0;
    int         errors = 0;
    logic       sv_d = 1'b0;
    logic       quiet = 1'b1;

    irig_frame_sync #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .sym_in     (sym_in),
        .sym_valid  (sym_valid),
        .locked     (locked),
        .bit_index  (bit_index),
        .pps        (pps),
        .time_valid (time_valid),
        .sec_bcd    (sec_bcd),
        .min_bcd    (min_bcd),
        .hour_bcd   (hour_bcd),
        .day_bcd    (day_bcd),
        .year_bcd   (year_bcd),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) sv_d <= sym_valid;

    // Scoreboard: pop one expectation per sampled symbol; otherwise no strobes allowed
    always @(negedge clk) begin
        exp_t e;
        if (sv_d) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: symbol response with no expectation queued");
            end else begin
                e = sb.pop_front();
                if ({pps, time_valid, sync_err, locked, bit_index} !== e) begin
                    errors++;
                    $display("FAIL sb_sym got pps=%0b tv=%0b err=%0b lk=%0b idx=%0d exp pps=%0b tv=%0b err=%0b lk=%0b idx=%0d",
                             pps, time_valid, sync_err, locked, bit_index,
                             e.pps, e.tv, e.err, e.lk, e.idx);
                end
            end
        end else if (!quiet) begin
            checks++;
            if ({pps, time_valid, sync_err} !== 3'b000) begin
                errors++;
                $display("FAIL idle_pulse got pps=%0b tv=%0b err=%0b exp 000", pps, time_valid, sync_err);
            end
        end
    end

    task automatic drive_sym(input logic [1:0] s, input exp_t e);
        @(negedge clk);
        sym_in    = s;
        sym_valid = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        sym_valid = 1'b0;
        sym_in    = 2'd0;
    endtask

    task automatic build_frame(input logic [6:0] s, input logic [6:0] m, input logic [5:0] h,
                               input logic [9:0] d, input logic [7:0] y);
        for (int i = 0; i < 100; i++) frame[i] = (i == 0 || i % 10 == 9) ? 2'd2 : 2'd0;
        for (int b = 0; b < 4; b++) begin
            frame[1 + b]  = {1'b0, s[b]};
            frame[10 + b] = {1'b0, m[b]};
            frame[20 + b] = {1'b0, h[b]};
            frame[30 + b] = {1'b0, d[b]};
            frame[35 + b] = {1'b0, d[4 + b]};
            frame[50 + b] = {1'b0, y[b]};
            frame[55 + b] = {1'b0, y[4 + b]};
        end
        for (int b = 0; b < 3; b++) begin
            frame[6 + b]  = {1'b0, s[4 + b]};
            frame[15 + b] = {1'b0, m[4 + b]};
        end
        for (int b = 0; b < 2; b++) begin
            frame[25 + b] = {1'b0, h[4 + b]};
            frame[40 + b] = {1'b0, d[8 + b]};
        end
        // spare / unused slots carry ones; they must not reach any field
        frame[5]  = 2'd1;
        frame[44] = 2'd1;
    endtask

    task automatic send_unlocked(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) drive_sym(frame[k], exp_t'(0));
    endtask

    task automatic send_locked(input int lo, input int hi, input logic pub);
        exp_t e;
        for (int k = lo; k <= hi; k++) begin
            e     = '0;
            e.pps = (k == 0);
            e.tv  = (k == 99) && pub;
            e.lk  = 1'b1;
            e.idx = 7'(k);
            drive_sym(frame[k], e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({locked, bit_index, pps, time_valid, sync_err, sec_bcd, min_bcd, hour_bcd, day_bcd, year_bcd} !== '0) begin
            errors++;
            $display("FAIL reset_state got lk=%0b idx=%0d pps=%0b tv=%0b err=%0b exp all 0",
                     locked, bit_index, pps, time_valid, sync_err);
        end
        rst   = 1'b0;
        quiet = 1'b0;
    endtask

    task automatic test_frame_lock();
        build_frame(7'h56, 7'h34, 6'h12, 10'h123, 8'h24);
        send_unlocked(0, 99);
        send_locked(0, 99, 1'b1);
        checks++;
        if ({sec_bcd, min_bcd, hour_bcd, day_bcd, year_bcd} !== {7'h56, 7'h34, 6'h12, 10'h123, 8'h24}) begin
            errors++;
            $display("FAIL fields_first got sec=%h min=%h hour=%h day=%h yr=%h exp 56 34 12 123 24",
                     sec_bcd, min_bcd, hour_bcd, day_bcd, year_bcd);
        end
    endtask

    task automatic test_data_mismatch();
        send_locked(0, 38, 1'b0);
        drive_sym(2'd0, exp_t'({1'b0, 1'b0, 1'b1, 1'b0, 7'd0}));
        send_unlocked(40, 99);
        send_locked(0, 46, 1'b0);
    endtask

    task automatic test_marker_mismatch();
        drive_sym(2'd2, exp_t'({1'b0, 1'b0, 1'b1, 1'b0, 7'd0}));
        drive_sym(2'd2, exp_t'({1'b1, 1'b0, 1'b0, 1'b1, 7'd0}));
        send_locked(1, 99, 1'b1);
        checks++;
        if ({sec_bcd, min_bcd, hour_bcd, day_bcd, year_bcd} !== {7'h56, 7'h34, 6'h12, 10'h123, 8'h24}) begin
            errors++;
            $display("FAIL fields_relock got sec=%h min=%h hour=%h day=%h yr=%h exp 56 34 12 123 24",
                     sec_bcd, min_bcd, hour_bcd, day_bcd, year_bcd);
        end
    endtask

    task automatic test_illegal();
        send_locked(0, 3, 1'b0);
        drive_sym(2'd3, exp_t'({1'b0, 1'b0, 1'b1, 1'b0, 7'd0}));
        drive_sym(2'd3, exp_t'(0));
        drive_sym(2'd2, exp_t'(0));
        drive_sym(2'd3, exp_t'({1'b0, 1'b0, 1'b1, 1'b0, 7'd0}));
    endtask

    task automatic test_timeout();
        int   n;
        logic seen;
        drive_sym(2'd2, exp_t'(0));
        drive_sym(2'd2, exp_t'({1'b1, 1'b0, 1'b0, 1'b1, 7'd0}));
        drive_sym(2'd0, exp_t'({1'b0, 1'b0, 1'b0, 1'b1, 7'd1}));
        quiet = 1'b1;
        n = 0;
        while (n < TMO + 20 && sync_err !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sync_err !== 1'b1 || n < TMO - 1 || n > TMO + 1) begin
            errors++;
            $display("FAIL timeout_err got err=%0b after %0d cycles exp err=1 after %0d cycles", sync_err, n, TMO);
        end
        checks++;
        if ({locked, bit_index} !== 8'd0) begin
            errors++;
            $display("FAIL timeout_state got lk=%0b idx=%0d exp lk=0 idx=0", locked, bit_index);
        end
        checks++;
        if ({sec_bcd, min_bcd, hour_bcd, day_bcd, year_bcd} !== {7'h56, 7'h34, 6'h12, 10'h123, 8'h24}) begin
            errors++;
            $display("FAIL timeout_fields got sec=%h min=%h hour=%h day=%h yr=%h exp 56 34 12 123 24",
                     sec_bcd, min_bcd, hour_bcd, day_bcd, year_bcd);
        end
        @(negedge clk);
        seen = 1'b0;
        for (int i = 0; i < 2 * TMO; i++) begin
            @(negedge clk);
            if (sync_err !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL hunt_no_timeout got sync_err pulse in HUNT exp none");
        end
        quiet = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        drive_sym(2'd2, exp_t'(0));
        send_locked(0, 5, 1'b0);
        @(negedge clk);
        rst       = 1'b1;
        sym_in    = 2'd2;
        sym_valid = 1'b1;
        sb.push_back(exp_t'(0));
        @(negedge clk);
        checks++;
        if ({locked, bit_index, pps, time_valid, sync_err, sec_bcd, min_bcd, hour_bcd, day_bcd, year_bcd} !== '0) begin
            errors++;
            $display("FAIL reset_mid got lk=%0b idx=%0d sec=%h day=%h yr=%h exp all 0",
                     locked, bit_index, sec_bcd, day_bcd, year_bcd);
        end
        rst       = 1'b0;
        sym_valid = 1'b0;
        sym_in    = 2'd0;
    endtask

    task automatic test_second_time();
        build_frame(7'h58, 7'h59, 6'h23, 10'h366, 8'h99);
        send_unlocked(0, 99);
        send_locked(0, 99, 1'b1);
        checks++;
        if ({sec_bcd, min_bcd, hour_bcd, day_bcd, year_bcd} !== {7'h58, 7'h59, 6'h23, 10'h366, 8'h99}) begin
            errors++;
            $display("FAIL fields_second got sec=%h min=%h hour=%h day=%h yr=%h exp 58 59 23 366 99",
                     sec_bcd, min_bcd, hour_bcd, day_bcd, year_bcd);
        end
    endtask

    initial begin
        test_reset();
        test_frame_lock();
        test_data_mismatch();
        test_marker_mismatch();
        test_illegal();
        test_timeout();
        test_reset_mid_frame();
        test_second_time();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d pending exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
